// File: rtl/iomem_nibble_bridge.sv
// iomem_nibble_bridge: narrows the picosoc 32-bit iomem bus onto a framed 4-bit serial bus
module iomem_nibble_bridge #(
  parameter int HALF = 2,
  parameter int ADDR_NIBBLES = 6,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        xb_clk,
  output logic        xb_csb,
  output logic [3:0]  xb_do,
  input  logic [3:0]  xb_di,
  input  logic        xb_rdy,
  output logic        xb_timeout
);
  localparam int P = 2 * HALF;
  localparam int PW = $clog2(P);
  localparam int AW = 4 * ADDR_NIBBLES;
  localparam int CM = TIMEOUT > 8 ? (TIMEOUT > ADDR_NIBBLES ? TIMEOUT : ADDR_NIBBLES) : (ADDR_NIBBLES > 8 ? ADDR_NIBBLES : 8);
  localparam int CW = $clog2(CM);
  localparam logic [PW-1:0] PH_LAST = PW'(P - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(HALF);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_NIBBLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] D_LAST = CW'(7);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, WAIT, RDATA, DONE, GAP} state_t;
  state_t state, state_n;
  logic [PW-1:0] ph;
  logic [CW-1:0] cnt;
  logic [3:0] wstrb;
  logic [31:0] addr_sh, wdata_sh;
  logic [27:0] rsh;
  logic pend, wr, last, framing;
  assign pend = ph == PH_LAST;
  assign wr = |wstrb;
  assign last = cnt == (state == ADDR ? A_LAST : state == WAIT ? T_LAST : D_LAST);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ph <= '0;
      cnt <= '0;
      wstrb <= '0;
      addr_sh <= '0;
      wdata_sh <= '0;
      rsh <= '0;
      iomem_rdata <= '0;
      xb_timeout <= 1'b0;
    end else begin
      state <= state_n;
      ph <= (state == IDLE || state == DONE || pend) ? '0 : ph + 1'b1;
      cnt <= state_n != state ? '0 : pend ? cnt + 1'b1 : cnt;
      if (state == IDLE && iomem_valid) begin
        wstrb <= iomem_wstrb;
        addr_sh <= iomem_addr << (32 - AW);
        wdata_sh <= iomem_wdata;
      end
      if (pend && state == ADDR) addr_sh <= addr_sh << 4;
      if (pend && state == WDATA) wdata_sh <= wdata_sh << 4;
      if (pend && state == RDATA) rsh <= {rsh[23:0], xb_di};
      if (pend && state == RDATA && last) iomem_rdata <= {rsh, xb_di};
      if (pend && state == WAIT && !xb_rdy && last) begin
        iomem_rdata <= '1;
        xb_timeout <= 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = iomem_valid ? CMD : IDLE;
      CMD:     state_n = pend ? ADDR : CMD;
      ADDR:    state_n = pend && last ? (wr ? WDATA : WAIT) : ADDR;
      WDATA:   state_n = pend && last ? WAIT : WDATA;
      WAIT:    state_n = !pend ? WAIT : xb_rdy ? (wr ? DONE : RDATA) : last ? DONE : WAIT;
      RDATA:   state_n = pend && last ? DONE : RDATA;
      DONE:    state_n = GAP;
      GAP:     state_n = pend ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    framing = state inside {CMD, ADDR, WDATA, WAIT, RDATA};
    iomem_ready = state == DONE;
    xb_csb = !framing;
    xb_clk = framing && ph >= PH_HALF;
    xb_do = state == CMD ? wstrb : state == ADDR ? addr_sh[31:28] : state == WDATA ? wdata_sh[31:28] : 4'h0;
  end
endmodule

// File: doc/iomem_nibble_bridge.md
# iomem_nibble_bridge

Narrows the picosoc 32-bit iomem bus (valid/ready/wstrb/addr/wdata/rdata) onto a 4-bit framed serial bus so external memory-mapped peripherals stay reachable with ~11 pads instead of ~100. Sits between the core's iomem port and the IO pad ring. Each iomem transfer becomes one chip-select frame: a command nibble, address, and either write data or read data.

## Interface
- HALF, 2: clk cycles per half bit period (≥1); bit period P = 2·HALF clk cycles
- ADDR_NIBBLES, 6: address nibbles sent, taken from addr[4·ADDR_NIBBLES-1:0] (1..8)
- TIMEOUT, 255: max bit periods spent waiting for xb_rdy (≥1)

- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- iomem_valid  in  1  core request; held until iomem_ready
- iomem_ready  out  1  one-cycle completion pulse
- iomem_wstrb  in  4  byte strobes; 0000 = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data; valid in the iomem_ready cycle
- xb_clk  out  1  serial bus clock to pads
- xb_csb  out  1  frame select, active low
- xb_do  out  4  nibble out, MSB nibble first
- xb_di  in  4  nibble in from peripheral
- xb_rdy  in  1  peripheral ready/acknowledge
- xb_timeout  out  1  sticky: a frame timed out

## Operation
- One clock `clk`. Reset `reset` is synchronous and active-high.
- States: IDLE, CMD, ADDR, WDATA, WAIT, RDATA, DONE, GAP.
- IDLE: when iomem_valid=1, capture wstrb/addr/wdata and go to CMD. Later changes on the iomem inputs are ignored until DONE.
- CMD: 1 period, xb_do = captured wstrb.
- ADDR: ADDR_NIBBLES periods, address MSB nibble first.
- WDATA: writes only (wstrb≠0), 8 periods, wdata[31:28] first.
- WAIT: xb_do = 0. Sample xb_rdy once per period.
  - xb_rdy=1: write → DONE, read → RDATA.
  - TIMEOUT periods with no rdy: set xb_timeout, load rdata = 32'hFFFF_FFFF, go to DONE (RDATA skipped).
- RDATA: 8 periods. Sample xb_di once per period and shift into rdata from the MSB end.
- DONE: 1 clk. iomem_ready=1, iomem_rdata updated (writes leave it unchanged), xb_csb returns high.
- GAP: xb_csb high, xb_clk low for one full period, then IDLE. The next request is accepted no earlier than the end of GAP.
- A new request after a timeout proceeds normally. xb_timeout clears only on reset.

## Timing
- Reset values: iomem_ready=0, iomem_rdata=0, xb_clk=0, xb_csb=1, xb_do=0, xb_timeout=0. State = IDLE, all counters 0.
- Accept edge k: xb_csb falls and the CMD nibble is driven from cycle k+1.
- Per period, xb_do/xb_csb change only at period start. xb_clk is 0 for the first HALF cycles and 1 for the last HALF cycles. The peripheral samples on xb_clk rising.
- The bridge samples xb_di/xb_rdy on the last clk cycle of the period (the edge where xb_clk falls).
- Latency, both directions, rdy high at the first WAIT sample: frame = (1+ADDR_NIBBLES+9) periods. iomem_ready at cycle k+1+P·(ADDR_NIBBLES+10). Defaults: k+65.
- Each extra WAIT period adds P cycles.
- Timeout read: iomem_ready at k+1+P·(ADDR_NIBBLES+1+TIMEOUT).
- Minimum request spacing: ready pulse, then P GAP cycles, then IDLE.
- iomem_valid that stays high in the DONE cycle is not re-accepted. The core drops it after ready.
- Reset mid-frame: the next cycle forces reset values. No iomem_ready pulse is produced; the frame is abandoned.
- iomem_ready is never asserted while iomem_valid=0 was sampled at accept (accept requires valid=1).

## Test plan
- Write, defaults: addr=0x0300_1234, wdata=0xDEADBEEF, wstrb=1111, rdy held 1.
  - xb_do sequence: F,0,0,1,2,3,4,D,E,A,D,B,E,E,F.
  - iomem_ready at k+65; rdata stays 0.
- Read: wstrb=0000, addr=0x0000_0040, peripheral drives rdy, then nibbles 1..8.
  - xb_do: 0,0,0,0,0,4,0.
  - iomem_rdata=0x1234_5678 at k+65.
- Wait states: read with rdy low for 3 periods.
  - ready at k+77; xb_timeout stays 0.
- Timeout: TIMEOUT=4, rdy never high, read.
  - rdata=0xFFFF_FFFF; xb_timeout=1 persists through the next successful write; cleared only by reset.
- Reset asserted at cycle k+30 of a write.
  - Next cycle: xb_csb=1, xb_clk=0, xb_do=0. No ready pulse.
  - A new request after reset completes normally.
- Back-to-back: valid held high across two requests.
  - Second frame's csb falls ≥P+1 cycles after the first ready pulse.
  - HALF=1 and ADDR_NIBBLES=8 variants: 8 address nibbles, P=2.
